// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle for trap_ctrl.
// The slave modport belongs to the trap controller; the master modport belongs to the pipeline/CSR file.
interface trap_ctrl_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned NUM_LIRQ = 16
);
  logic                csr_mstatus_mie_i;
  logic                csr_mstatus_mpie_i;
  logic [XLEN-1:0]     csr_mie_i;
  logic [XLEN-1:0]     csr_mtvec_i;
  logic [XLEN-1:0]     csr_mepc_i;
  logic                int_soft_i;
  logic                int_timer_i;
  logic                int_exter_i;
  logic [NUM_LIRQ-1:0] int_local_i;
  logic                wb_valid_i;
  logic [PC_WIDTH-1:0] wb_pc_i;
  logic                wb_excp_i;
  logic [4:0]          wb_excp_code_i;
  logic [XLEN-1:0]     wb_excp_tval_i;
  logic                wb_mret_i;
  logic                csr_mcause_wen_o;
  logic                csr_mepc_wen_o;
  logic                csr_mtval_wen_o;
  logic                csr_mstatus_wen_o;
  logic [XLEN-1:0]     csr_mcause_o;
  logic [XLEN-1:0]     csr_mepc_o;
  logic [XLEN-1:0]     csr_mtval_o;
  logic                csr_mstatus_mie_o;
  logic                csr_mstatus_mpie_o;
  logic                trap_stall_o;
  logic                trap_flush_o;
  logic [PC_WIDTH-1:0] trap_flush_pc_o;

  modport master (
    output csr_mstatus_mie_i, csr_mstatus_mpie_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    output int_soft_i, int_timer_i, int_exter_i, int_local_i,
    output wb_valid_i, wb_pc_i, wb_excp_i, wb_excp_code_i, wb_excp_tval_i, wb_mret_i,
    input  csr_mcause_wen_o, csr_mepc_wen_o, csr_mtval_wen_o, csr_mstatus_wen_o,
    input  csr_mcause_o, csr_mepc_o, csr_mtval_o, csr_mstatus_mie_o, csr_mstatus_mpie_o,
    input  trap_stall_o, trap_flush_o, trap_flush_pc_o
  );

  modport slave (
    input  csr_mstatus_mie_i, csr_mstatus_mpie_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    input  int_soft_i, int_timer_i, int_exter_i, int_local_i,
    input  wb_valid_i, wb_pc_i, wb_excp_i, wb_excp_code_i, wb_excp_tval_i, wb_mret_i,
    output csr_mcause_wen_o, csr_mepc_wen_o, csr_mtval_wen_o, csr_mstatus_wen_o,
    output csr_mcause_o, csr_mepc_o, csr_mtval_o, csr_mstatus_mie_o, csr_mstatus_mpie_o,
    output trap_stall_o, trap_flush_o, trap_flush_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Registered machine-mode trap sequencer: decides at a writeback retirement, then spends one
// cycle writing CSRs (COMMIT) and one cycle redirecting fetch (REDIRECT).
module trap_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned NUM_LIRQ    = 16,
  parameter bit          VECTORED_EN = 1'b1
) (
  input logic         clk_i,
  input logic         rst_n_i,
  trap_ctrl_if.slave  tc_if
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMMIT   = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0]          r_state;
  logic                r_pend_ext, r_pend_soft, r_pend_tmr;
  logic [NUM_LIRQ-1:0] r_pend_loc;
  logic                r_is_mret;
  logic [XLEN-1:0]     r_cause, r_mepc, r_mtval;
  logic                r_mie_new, r_mpie_new;
  logic [PC_WIDTH-1:0] r_flush_pc;

  logic [4:0]          w_irq_code;
  logic                w_irq_any, w_irq_elig, w_vec_en, w_commit, w_trap_wen, w_redirect;
  logic [PC_WIDTH-1:0] w_base, w_pc4, w_int_target;
  logic                w_unused;

  // Last assignment wins, so the loop and the checks run from lowest to highest priority.
  always_comb begin
    w_irq_code = 5'd0;
    for (int i = int'(NUM_LIRQ) - 1; i >= 0; i--) begin
      if (r_pend_loc[i]) w_irq_code = 5'(16 + i);
    end
    if (r_pend_tmr)  w_irq_code = 5'd7;
    if (r_pend_soft) w_irq_code = 5'd3;
    if (r_pend_ext)  w_irq_code = 5'd11;
  end

  assign w_irq_any    = r_pend_ext | r_pend_soft | r_pend_tmr | (|r_pend_loc);
  assign w_irq_elig   = w_irq_any & tc_if.csr_mstatus_mie_i;
  assign w_vec_en     = VECTORED_EN && (tc_if.csr_mtvec_i[1:0] == 2'b01);
  assign w_base       = {tc_if.csr_mtvec_i[PC_WIDTH-1:2], 2'b00};
  assign w_pc4        = tc_if.wb_pc_i + PC_WIDTH'(4);
  assign w_int_target = w_vec_en ? w_base + PC_WIDTH'({w_irq_code, 2'b00}) : w_base;
  assign w_unused     = ^{tc_if.csr_mie_i, tc_if.csr_mtvec_i, tc_if.csr_mepc_i};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_pend_ext  <= 1'b0;
      r_pend_soft <= 1'b0;
      r_pend_tmr  <= 1'b0;
      r_pend_loc  <= '0;
      r_is_mret   <= 1'b0;
      r_cause     <= '0;
      r_mepc      <= '0;
      r_mtval     <= '0;
      r_mie_new   <= 1'b0;
      r_mpie_new  <= 1'b0;
      r_flush_pc  <= '0;
    end else begin
      r_pend_ext  <= tc_if.int_exter_i & tc_if.csr_mie_i[11];
      r_pend_soft <= tc_if.int_soft_i  & tc_if.csr_mie_i[3];
      r_pend_tmr  <= tc_if.int_timer_i & tc_if.csr_mie_i[7];
      r_pend_loc  <= tc_if.int_local_i & tc_if.csr_mie_i[16 +: NUM_LIRQ];
      unique case (r_state)
        ST_IDLE: begin
          if (tc_if.wb_valid_i) begin
            if (tc_if.wb_mret_i) begin
              r_state    <= ST_COMMIT;
              r_is_mret  <= 1'b1;
              r_mie_new  <= tc_if.csr_mstatus_mpie_i;
              r_mpie_new <= 1'b1;
              r_flush_pc <= tc_if.csr_mepc_i[PC_WIDTH-1:0];
            end else if (tc_if.wb_excp_i) begin
              r_state    <= ST_COMMIT;
              r_is_mret  <= 1'b0;
              r_cause    <= XLEN'(tc_if.wb_excp_code_i);
              r_mepc     <= XLEN'(tc_if.wb_pc_i);
              r_mtval    <= tc_if.wb_excp_tval_i;
              r_mie_new  <= 1'b0;
              r_mpie_new <= tc_if.csr_mstatus_mie_i;
              r_flush_pc <= w_base;
            end else if (w_irq_elig) begin
              // The retiring instruction completes, so the interrupt returns past it.
              r_state    <= ST_COMMIT;
              r_is_mret  <= 1'b0;
              r_cause    <= {1'b1, (XLEN-1)'(w_irq_code)};
              r_mepc     <= XLEN'(w_pc4);
              r_mtval    <= '0;
              r_mie_new  <= 1'b0;
              r_mpie_new <= tc_if.csr_mstatus_mie_i;
              r_flush_pc <= w_int_target;
            end
          end
        end
        ST_COMMIT:   r_state <= ST_REDIRECT;
        ST_REDIRECT: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_commit   = (r_state == ST_COMMIT);
  assign w_redirect = (r_state == ST_REDIRECT);
  assign w_trap_wen = w_commit & ~r_is_mret;

  assign tc_if.csr_mcause_wen_o   = w_trap_wen;
  assign tc_if.csr_mepc_wen_o     = w_trap_wen;
  assign tc_if.csr_mtval_wen_o    = w_trap_wen;
  assign tc_if.csr_mstatus_wen_o  = w_commit;
  assign tc_if.csr_mcause_o       = w_trap_wen ? r_cause : '0;
  assign tc_if.csr_mepc_o         = w_trap_wen ? r_mepc  : '0;
  assign tc_if.csr_mtval_o        = w_trap_wen ? r_mtval : '0;
  assign tc_if.csr_mstatus_mie_o  = w_commit & r_mie_new;
  assign tc_if.csr_mstatus_mpie_o = w_commit & r_mpie_new;
  assign tc_if.trap_stall_o       = w_commit | w_redirect;
  assign tc_if.trap_flush_o       = w_redirect;
  assign tc_if.trap_flush_pc_o    = w_redirect ? r_flush_pc : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, reset/stall corner sequences, and random
// retirements checked against a rule-level model of trap selection.
module tb_trap_ctrl;
  localparam int KNONE = 0;
  localparam int KTRAP = 1;
  localparam int KMRET = 2;

  typedef struct {
    logic [31:0] mtvec, mie_csr, mepc;
    logic        smie, mpie;
    logic [2:0]  irq;  // {exter, soft, timer}
    logic [15:0] lirq;
    logic [31:0] pc;
    logic        excp;
    logic [4:0]  code;
    logic [31:0] tval;
    logic        mret;
    int          kind;
    logic [31:0] e_cause, e_mepc, e_mtval, e_pc;
    logic        e_mie, e_mpie;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32), .PC_WIDTH(32), .NUM_LIRQ(16)) tif ();

  trap_ctrl #(.XLEN(32), .PC_WIDTH(32), .NUM_LIRQ(16), .VECTORED_EN(1'b1)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .tc_if   (tif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] mtvec, input logic [31:0] mie_csr,
                              input logic smie, input logic mpie, input logic [31:0] mepc,
                              input logic [2:0] irq, input logic [15:0] lirq,
                              input logic [31:0] pc, input logic excp, input logic [4:0] code,
                              input logic [31:0] tval, input logic mret);
    vec_t v;
    v.mtvec = mtvec; v.mie_csr = mie_csr; v.smie = smie; v.mpie = mpie; v.mepc = mepc;
    v.irq = irq; v.lirq = lirq; v.pc = pc; v.excp = excp; v.code = code; v.tval = tval;
    v.mret = mret; v.kind = KNONE; v.e_cause = 0; v.e_mepc = 0; v.e_mtval = 0; v.e_pc = 0;
    v.e_mie = 0; v.e_mpie = 0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t v, input int kind, input logic [31:0] cause,
                                    input logic [31:0] mepc, input logic [31:0] mtval,
                                    input logic mie, input logic mpie, input logic [31:0] fpc);
    v.kind = kind; v.e_cause = cause; v.e_mepc = mepc; v.e_mtval = mtval;
    v.e_mie = mie; v.e_mpie = mpie; v.e_pc = fpc;
    return v;
  endfunction

  // Reference: the mie bit index of each interrupt equals its cause code, so pending is
  // raw[code] & mie[code]; walk the causes in priority order.
  function automatic vec_t model(input vec_t v);
    logic [31:0] raw;
    int          prio[19];
    int          code;
    logic [31:0] base;
    raw = {v.lirq, 16'h0};
    raw[11] = v.irq[2];
    raw[3]  = v.irq[1];
    raw[7]  = v.irq[0];
    prio[0] = 11; prio[1] = 3; prio[2] = 7;
    for (int i = 0; i < 16; i++) prio[3+i] = 16 + i;
    base = v.mtvec & 32'hFFFF_FFFC;
    code = -1;
    for (int i = 18; i >= 0; i--) if (raw[prio[i]] && v.mie_csr[prio[i]]) code = prio[i];
    if (v.mret)
      return with_exp(v, KMRET, 0, 0, 0, v.mpie, 1'b1, v.mepc);
    if (v.excp)
      return with_exp(v, KTRAP, {27'h0, v.code}, v.pc, v.tval, 1'b0, v.smie, base);
    if (code >= 0 && v.smie)
      return with_exp(v, KTRAP, 32'h8000_0000 + code, v.pc + 32'd4, 0, 1'b0, 1'b1,
                      (v.mtvec % 4 == 1) ? base + 4 * code : base);
    return with_exp(v, KNONE, 0, 0, 0, 1'b0, 1'b0, 0);
  endfunction

  task automatic drive_wb_garbage(input logic en);
    tif.wb_valid_i     = en;
    tif.wb_excp_i      = 1'($urandom_range(0, 1));
    tif.wb_mret_i      = 1'($urandom_range(0, 1));
    tif.wb_excp_code_i = 5'($urandom);
    tif.wb_pc_i        = $urandom;
  endtask

  // Called at #1 after a posedge with wb_valid low; returns in the same phase.
  task automatic run_seq(input vec_t v, input string tag);
    logic tr, mr;
    tr = (v.kind == KTRAP);
    mr = (v.kind == KMRET);
    tif.csr_mtvec_i = v.mtvec; tif.csr_mie_i = v.mie_csr; tif.csr_mepc_i = v.mepc;
    tif.csr_mstatus_mie_i = v.smie; tif.csr_mstatus_mpie_i = v.mpie;
    {tif.int_exter_i, tif.int_soft_i, tif.int_timer_i} = v.irq;
    tif.int_local_i = v.lirq;
    tif.wb_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tif.wb_valid_i = 1'b1; tif.wb_pc_i = v.pc; tif.wb_excp_i = v.excp;
    tif.wb_excp_code_i = v.code; tif.wb_excp_tval_i = v.tval; tif.wb_mret_i = v.mret;
    @(posedge clk);
    #1 drive_wb_garbage(tr | mr);
    @(negedge clk);
    chk({tag, ".mcause_wen"}, tif.csr_mcause_wen_o, tr);
    chk({tag, ".mepc_wen"}, tif.csr_mepc_wen_o, tr);
    chk({tag, ".mtval_wen"}, tif.csr_mtval_wen_o, tr);
    chk({tag, ".mstatus_wen"}, tif.csr_mstatus_wen_o, tr | mr);
    chk({tag, ".stall_commit"}, tif.trap_stall_o, tr | mr);
    chk({tag, ".flush_commit"}, tif.trap_flush_o, 1'b0);
    if (tr) begin
      chk({tag, ".mcause"}, tif.csr_mcause_o, v.e_cause);
      chk({tag, ".mepc"}, tif.csr_mepc_o, v.e_mepc);
      chk({tag, ".mtval"}, tif.csr_mtval_o, v.e_mtval);
    end
    if (tr | mr) begin
      chk({tag, ".mie_o"}, tif.csr_mstatus_mie_o, v.e_mie);
      chk({tag, ".mpie_o"}, tif.csr_mstatus_mpie_o, v.e_mpie);
    end
    @(posedge clk);
    #1 drive_wb_garbage(tr | mr);
    @(negedge clk);
    chk({tag, ".flush"}, tif.trap_flush_o, tr | mr);
    chk({tag, ".stall_redir"}, tif.trap_stall_o, tr | mr);
    chk({tag, ".mstatus_wen_redir"}, tif.csr_mstatus_wen_o, 1'b0);
    if (tr | mr) chk({tag, ".flush_pc"}, tif.trap_flush_pc_o, v.e_pc);
    @(posedge clk);
    #1 tif.wb_valid_i = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_flush"}, tif.trap_flush_o, 1'b0);
    chk({tag, ".idle_stall"}, tif.trap_stall_o, 1'b0);
    chk({tag, ".idle_wen"}, tif.csr_mstatus_wen_o, 1'b0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = with_exp(mk(32'h100, 0, 1, 0, 0, 3'b000, 0, 32'h80, 1, 5'd2, 32'hDEAD, 0),
                       KTRAP, 32'h2, 32'h80, 32'hDEAD, 0, 1, 32'h100);
    tbl[1]  = with_exp(mk(32'h201, 32'h80, 1, 0, 0, 3'b001, 0, 32'h40, 0, 0, 0, 0),
                       KTRAP, 32'h8000_0007, 32'h44, 0, 0, 1, 32'h21C);
    tbl[2]  = with_exp(mk(32'h301, 32'h10888, 1, 0, 0, 3'b110, 16'h1, 32'h200, 1, 5'd5,
                          32'h11, 0), KTRAP, 32'h5, 32'h200, 32'h11, 0, 1, 32'h300);
    tbl[3]  = with_exp(mk(32'h301, 32'h10888, 1, 0, 0, 3'b110, 16'h1, 32'h200, 0, 5'd5,
                          32'h11, 0), KTRAP, 32'h8000_000B, 32'h204, 0, 0, 1, 32'h32C);
    tbl[4]  = with_exp(mk(32'h101, 32'hFFFF_0000, 1, 0, 0, 3'b000, 16'h28, 32'h10, 0, 0, 0, 0),
                       KTRAP, 32'h8000_0013, 32'h14, 0, 0, 1, 32'h14C);
    tbl[5]  = with_exp(mk(32'h100, 32'h80, 0, 1, 32'h44, 3'b001, 0, 32'h60, 0, 0, 0, 1),
                       KMRET, 0, 0, 0, 1, 1, 32'h44);
    tbl[6]  = with_exp(mk(32'h100, 32'h80, 0, 1, 0, 3'b001, 0, 32'h60, 0, 0, 0, 0),
                       KNONE, 0, 0, 0, 0, 0, 0);
    tbl[7]  = with_exp(mk(32'h100, 32'h0, 1, 0, 0, 3'b111, 16'hFFFF, 32'h60, 0, 0, 0, 0),
                       KNONE, 0, 0, 0, 0, 0, 0);
    tbl[8]  = with_exp(mk(32'h400, 32'h8, 1, 0, 0, 3'b010, 0, 32'hFFFF_FFFC, 0, 0, 0, 0),
                       KTRAP, 32'h8000_0003, 32'h0, 0, 0, 1, 32'h400);
    tbl[9]  = with_exp(mk(32'h1000, 0, 0, 1, 0, 3'b000, 0, 32'h500, 1, 5'd11, 0, 0),
                       KTRAP, 32'hB, 32'h500, 0, 0, 0, 32'h1000);
    tbl[10] = with_exp(mk(32'h100, 0, 1, 0, 32'h1234, 3'b000, 0, 32'h60, 1, 5'd3, 32'h5, 1),
                       KMRET, 0, 0, 0, 0, 1, 32'h1234);
    tbl[11] = with_exp(mk(32'h202, 32'h80, 1, 0, 0, 3'b001, 0, 32'h8, 0, 0, 0, 0),
                       KTRAP, 32'h8000_0007, 32'hC, 0, 0, 1, 32'h200);

    tif.csr_mstatus_mie_i = 0; tif.csr_mstatus_mpie_i = 0; tif.csr_mie_i = 0;
    tif.csr_mtvec_i = 0; tif.csr_mepc_i = 0; tif.int_soft_i = 0; tif.int_timer_i = 0;
    tif.int_exter_i = 0; tif.int_local_i = 0; tif.wb_valid_i = 0; tif.wb_pc_i = 0;
    tif.wb_excp_i = 0; tif.wb_excp_code_i = 0; tif.wb_excp_tval_i = 0; tif.wb_mret_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.stall", tif.trap_stall_o, 1'b0);
    chk("reset.flush", tif.trap_flush_o, 1'b0);
    chk("reset.mstatus_wen", tif.csr_mstatus_wen_o, 1'b0);
    chk("reset.mcause_wen", tif.csr_mcause_wen_o, 1'b0);
    chk("reset.flush_pc", tif.trap_flush_pc_o, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) run_seq(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted during COMMIT must cancel the pending redirect.
    tif.csr_mtvec_i = 32'h100; tif.csr_mie_i = 0; tif.csr_mstatus_mie_i = 1;
    {tif.int_exter_i, tif.int_soft_i, tif.int_timer_i} = 3'b000; tif.int_local_i = 0;
    @(posedge clk);
    #1;
    tif.wb_valid_i = 1; tif.wb_excp_i = 1; tif.wb_mret_i = 0; tif.wb_excp_code_i = 5'd4;
    tif.wb_pc_i = 32'h90;
    @(posedge clk);
    #1 tif.wb_valid_i = 0;
    @(negedge clk);
    chk("rst_mid.commit_wen", tif.csr_mcause_wen_o, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.flush", tif.trap_flush_o, 1'b0);
    chk("rst_mid.stall", tif.trap_stall_o, 1'b0);
    chk("rst_mid.wen", tif.csr_mstatus_wen_o, 1'b0);
    chk("rst_mid.mcause", tif.csr_mcause_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.flush_after", tif.trap_flush_o, 1'b0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] r_mtvec, r_pc, r_lirq;
      r_mtvec = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
      r_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      r_lirq  = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      rv = mk(r_mtvec, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              $urandom, 3'($urandom_range(0, 7)), r_lirq[15:0], r_pc,
              1'($urandom_range(0, 3) == 0), 5'($urandom), $urandom,
              1'($urandom_range(0, 6) == 0));
      rv = model(rv);
      run_seq(rv, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
